pc_call_stack: RTL

- Hardware return-address stack that produces the FROM_STACK operand for the PC next-address mux in the RAT CPU.
- On CALL, or on interrupt entry to vector 0x3FF, the control unit pushes the return address.
- On RET/RETIE it pops. FROM_STACK always shows the current top, so the PC loads it on the same edge as the pop.
- Sits between the control unit and the PC mux; replaces keeping return addresses in scratch RAM.

---
 rtl/pc_call_stack.sv | 114 +++++++++++
 1 files changed

// File: rtl/pc_call_stack.sv
// pc_call_stack
//   Hardware return-address stack for the RAT CPU. The control unit pushes
//   return addresses on CALL and on interrupt entry, and pops them on
//   RET/RETIE. FROM_STACK always shows the current top entry, so the PC mux
//   can load it on the same edge that pops it.
//
// Ports
//   CLK        in   system clock, rising edge
//   RST_N      in   asynchronous active-low reset
//   PUSH       in   push PUSH_DATA this cycle
//   POP        in   pop the top entry this cycle
//   PUSH_DATA  in   [WIDTH-1:0] return address to push
//   CLR_ERR    in   synchronous clear of the sticky error flags
//   FROM_STACK out  [WIDTH-1:0] current top of stack, 0 when empty
//   COUNT      out  [AW:0] number of valid entries, 0..DEPTH
//   EMPTY      out  COUNT == 0
//   FULL       out  COUNT == DEPTH
//   OVERFLOW   out  sticky, push attempted while full
//   UNDERFLOW  out  sticky, pop attempted while empty
module pc_call_stack #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 32,
    parameter int AW    = 5
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             PUSH,
    input  logic             POP,
    input  logic [WIDTH-1:0] PUSH_DATA,
    input  logic             CLR_ERR,
    output logic [WIDTH-1:0] FROM_STACK,
    output logic [AW:0]      COUNT,
    output logic             EMPTY,
    output logic             FULL,
    output logic             OVERFLOW,
    output logic             UNDERFLOW
);

    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      count;
    logic             overflow;
    logic             underflow;

    logic             empty;
    logic             full;
    logic [AW-1:0]    top_idx;
    logic             replace;
    logic             inc;
    logic             dec;
    logic             wr_en;
    logic [AW-1:0]    wr_idx;
    logic             ovf_set;
    logic             unf_set;

    always_comb begin
        empty   = (count == '0);
        full    = (count == DEPTH_C);
        top_idx = AW'(count - 1'b1);

        // Push+pop on a non-empty stack overwrites the top in place, even
        // when full. Push+pop on an empty stack degenerates to a plain push
        // (into slot 0) but still reports the illegal pop.
        replace = PUSH & POP & ~empty;
        inc     = (PUSH & ~POP & ~full) | (PUSH & POP & empty);
        dec     = POP & ~PUSH & ~empty;
        wr_en   = inc | replace;
        wr_idx  = replace ? top_idx : AW'(count);

        ovf_set = PUSH & ~POP & full;
        unf_set = POP & empty;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (inc)
                count <= count + 1'b1;
            else if (dec)
                count <= count - 1'b1;

            // An error raised in the same cycle as CLR_ERR takes precedence.
            if (ovf_set)
                overflow <= 1'b1;
            else if (CLR_ERR)
                overflow <= 1'b0;

            if (unf_set)
                underflow <= 1'b1;
            else if (CLR_ERR)
                underflow <= 1'b0;
        end
    end

    // Storage is not reset; writes are suppressed while reset is held so an
    // in-flight push is discarded.
    always_ff @(posedge CLK) begin
        if (RST_N && wr_en)
            mem[wr_idx] <= PUSH_DATA;
    end

    // Masked with empty so stale or uninitialised entries never leak out.
    assign FROM_STACK = empty ? '0 : mem[top_idx];
    assign COUNT      = count;
    assign EMPTY      = empty;
    assign FULL       = full;
    assign OVERFLOW   = overflow;
    assign UNDERFLOW  = underflow;

endmodule
